// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO with DEPTH entries of {instr, pc}.
// Define INSTR_QUEUE_BYPASS_EN to let an empty queue pass fetch straight to decode.
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic empty, full;
  logic enq, deq;
  logic bypass_take;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign in_ready = !full && !flush;
  assign count    = count_q;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic bypass;

  // An empty queue forwards fetch directly; a consumed bypass never touches storage.
  assign bypass      = empty && in_valid && !flush;
  assign bypass_take = bypass && out_ready;
  assign out_valid   = (!empty && !flush) || bypass;
  assign out_instr   = bypass ? in_instr : mem_q[head_q].instr;
  assign out_pc      = bypass ? in_pc    : mem_q[head_q].pc;
`else
  assign bypass_take = 1'b0;
  assign out_valid   = !empty && !flush;
  assign out_instr   = mem_q[head_q].instr;
  assign out_pc      = mem_q[head_q].pc;
`endif

  assign enq = in_valid && in_ready && !bypass_take;
  assign deq = out_valid && out_ready && !bypass_take;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (enq) tail_d = tail_q + AW'(1);
      if (deq) head_d = head_q + AW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: storage is reset too, so out_instr/out_pc read zero while reset is held.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq && !flush) mem_q[tail_q] <= '{instr: in_instr, pc: in_pc};
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_instr_queue;

  localparam int DEPTH = 4;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [$clog2(DEPTH):0] count;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] q_model[$];   // {instr, pc}, front = head
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .count     (count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0000_0013 ^ (pc << 8);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs follow from the current model contents and inputs.
  task automatic check_outputs();
    bit          byp;
    bit          exp_v;
    logic [63:0] head;
    byp   = BYP && (q_model.size() == 0) && in_valid && !flush;
    exp_v = ((q_model.size() != 0) && !flush) || byp;
    check("in_ready", in_ready, (q_model.size() < DEPTH) && !flush);
    check("out_valid", out_valid, exp_v);
    check("count", count, q_model.size());
    if (exp_v) begin
      head = byp ? {in_instr, in_pc} : q_model[0];
      check("out_instr", out_instr, head[63:32]);
      check("out_pc", out_pc, head[31:0]);
    end
  endtask

  task automatic model_edge();
    bit acc, take, pop;
    if (flush) begin
      q_model.delete();
    end else begin
      take = BYP && (q_model.size() == 0) && in_valid && out_ready;
      acc  = in_valid && (q_model.size() < DEPTH);
      pop  = (q_model.size() != 0) && out_ready;
      if (!take) begin
        if (pop) void'(q_model.pop_front());
        if (acc) q_model.push_back({in_instr, in_pc});
      end
    end
  endtask

  // One clock: drive inputs, check settled outputs, advance DUT and model.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl,
                       output bit accepted);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = rdy;
    flush     = fl;
    #1;
    check_outputs();
    accepted = v && !fl && (q_model.size() < DEPTH);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_pc = '0; in_instr = '0;
    reset = 1'b1;
    q_model.delete();
    @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", count, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;

    // Reset, then three entries with decode stalled.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, acc);
    #1;
    check("r029_count", count, 3);
    check("r029_out_pc", out_pc, 32'h0);
    check("r029_out_instr", out_instr, 32'h0000_0013);

    // Fill to DEPTH; a fifth offer is refused.
    cycle(1'b1, 32'hC, 1'b0, 1'b0, acc);
    check("r030_count", count, DEPTH);
    check("r030_in_ready", in_ready, 1'b0);
    cycle(1'b1, 32'h10, 1'b0, 1'b0, acc);
    check("r030_refused", acc, 1'b0);
    check("r030_count_hold", count, DEPTH);

    // Stream through a full queue across pointer wrap.
    next_pc = 32'h10;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      in_pc = next_pc; in_instr = instr_of(next_pc);
      #1;
      check("r031_wrap_pc", out_pc, 32'(k * 4));
      #0;
      cycle(1'b1, next_pc, 1'b1, 1'b0, acc);
      if (acc) next_pc += 32'h4;
    end

    // Flush with a concurrent enqueue offer, then restart.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h40, 1'b0, 1'b1, acc);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("r032_count", count, 0);
    check("r032_out_valid", out_valid, 1'b0);
    check("r032_in_ready", in_ready, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #1;
    check("r032_out_pc", out_pc, 32'h100);
    check("r032_out_valid2", out_valid, 1'b1);

    // Asynchronous reset mid-cycle with two entries queued.
    cycle(1'b1, 32'h104, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("r033_out_valid", out_valid, 1'b0);
    check("r033_count", count, 0);
    check("r033_out_pc", out_pc, 0);
    q_model.delete();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Empty queue, fetch offer with decode ready.
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    in_pc = 32'h104; in_instr = instr_of(32'h104);
    #1;
    check("r034_out_valid", out_valid, BYP);
    if (BYP) check("r034_out_pc", out_pc, 32'h104);
    @(posedge clk);
    model_edge();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("r034_next_valid", out_valid, !BYP);
    check("r034_next_count", count, BYP ? 0 : 1);
    check_outputs();

    // Random traffic against the model.
    do_reset();
    next_pc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(99) < 70, next_pc, $urandom_range(99) < 60,
            $urandom_range(99) < 3, acc);
      if (acc) next_pc += 32'h4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
